// File: rtl/reg_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_select_pkg
// Purpose  : Shared definitions for the register-select unit: instruction
//            field layout, field/C-width helpers, field-select encoding and
//            the per-bit one-hot decode function used by onehot_decoder.
// Ports    : none (package)
// Config   : none here; REG_SELECT_R0_ZERO_EN is consumed by reg_select_unit
// Revision : 1.0 - initial release
// ============================================================================
package reg_select_pkg;

  localparam int INSTR_W   = 32;
  localparam int OPC_W     = 5;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  // Register fields are packed MSB-first directly below the opcode.
  localparam int FIELD_MSB = OPC_LSB - 1;

  typedef enum logic [1:0] {
    FSEL_NONE = 2'd0,
    FSEL_RA   = 2'd1,
    FSEL_RB   = 2'd2,
    FSEL_RC   = 2'd3
  } field_sel_e;

  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

  // C occupies whatever is left below the opcode and three register fields.
  function automatic int c_width(input int idx_w);
    return INSTR_W - OPC_W - 3 * idx_w;
  endfunction

  // field: 0 = ra, 1 = rb, 2 = rc
  function automatic int field_lsb(input int idx_w, input int field);
    return FIELD_MSB - (field + 1) * idx_w + 1;
  endfunction

  // One bit of a one-hot decode: high when enabled and idx equals pos.
  function automatic logic onehot_bit(input logic [4:0] idx, input logic en,
                                      input int pos);
    return en && (int'(idx) == pos);
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder
// Purpose  : Index-to-one-hot decoder with enable; all zeros when disabled.
// Ports    : i_idx    [IDX_W]    register index
//            i_en     [1]        decode enable
//            o_onehot [NUM_REGS] one-hot vector (at most one bit set)
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decoder
  import reg_select_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  logic [4:0] w_idx5;
  assign w_idx5 = 5'(i_idx);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
    assign o_onehot[g] = onehot_bit(w_idx5, i_en, g);
  end

endmodule
`default_nettype wire

// File: rtl/reg_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_select_unit
// Purpose  : Holds an instruction register, sign-extends its C field and
//            turns gra/grb/grc + rin/rout/baout into registered one-hot
//            register write/read enables (latency 1), with a sticky error
//            flag for conflicting field selects.
// Ports    : clock, clear            clock / synchronous active-high reset
//            ir_in, instr[32]        IR load strobe and instruction
//            gra, grb, grc           field select (ra / rb / rc)
//            rin, rout, baout        write / read / base-address-read strobes
//            c_sign_extended[32]     sign-extended C field of IR
//            reg_in, reg_out         registered one-hot enables [NUM_REGS]
//            sel_idx[IDX_W]          index of the last valid selection
//            sel_valid               one-cycle pulse per valid selection
//            sel_err                 sticky multi-select flag
//            r0_zero                 BAout read of R0 (macro build only)
// Config   : `define REG_SELECT_R0_ZERO_EN makes baout of R0 read as zero
//            (r0_zero pulse instead of reg_out[0]); otherwise baout == rout.
//            NUM_REGS must be 16 or 32.
// Revision : 1.0 - initial release
// ============================================================================
module reg_select_unit
  import reg_select_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                ir_in,
  input  logic [31:0]         instr,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  output logic [31:0]         c_sign_extended,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                sel_valid,
  output logic                sel_err,
  output logic                r0_zero
);

  localparam int CW     = c_width(IDX_W);
  localparam int RA_LSB = field_lsb(IDX_W, 0);
  localparam int RB_LSB = field_lsb(IDX_W, 1);
  localparam int RC_LSB = field_lsb(IDX_W, 2);

  logic [31:0]         r_ir;
  logic [NUM_REGS-1:0] r_reg_in;
  logic [NUM_REGS-1:0] r_reg_out;
  logic [IDX_W-1:0]    r_sel_idx;
  logic                r_sel_valid;
  logic                r_sel_err;

  logic [OPC_W-1:0]    w_unused_opcode;
  logic [IDX_W-1:0]    w_ra, w_rb, w_rc, w_idx;
  field_sel_e          w_fsel;
  logic                w_multi;
  logic                w_fire;
  logic                w_wr_en, w_rd_en;
  logic [NUM_REGS-1:0] w_in_oh, w_out_oh;

  // The opcode is carried in IR but not decoded by this block.
  assign w_unused_opcode = r_ir[OPC_MSB:OPC_LSB];

  assign w_ra = r_ir[RA_LSB +: IDX_W];
  assign w_rb = r_ir[RB_LSB +: IDX_W];
  assign w_rc = r_ir[RC_LSB +: IDX_W];

  assign c_sign_extended = {{(INSTR_W - CW){r_ir[CW-1]}}, r_ir[CW-1:0]};

  always_comb begin
    w_fsel  = FSEL_NONE;
    w_multi = 1'b0;
    case ({gra, grb, grc})
      3'b000:  w_fsel  = FSEL_NONE;
      3'b100:  w_fsel  = FSEL_RA;
      3'b010:  w_fsel  = FSEL_RB;
      3'b001:  w_fsel  = FSEL_RC;
      default: w_multi = 1'b1;
    endcase
  end

  always_comb begin
    w_idx = '0;
    case (w_fsel)
      FSEL_RA: w_idx = w_ra;
      FSEL_RB: w_idx = w_rb;
      FSEL_RC: w_idx = w_rc;
      default: w_idx = '0;
    endcase
  end

  // A conflicting select leaves w_fsel at NONE, so it never fires.
  assign w_fire  = (w_fsel != FSEL_NONE) && (rin || rout || baout);
  assign w_wr_en = w_fire && rin;

`ifdef REG_SELECT_R0_ZERO_EN
  logic w_is_r0;
  logic w_r0z;
  logic r_r0_zero;

  assign w_is_r0 = (w_idx == '0);
  // baout of R0 reads a hardwired zero; a plain rout of R0 still reads it.
  assign w_rd_en = w_fire && (rout || (baout && !w_is_r0));
  assign w_r0z   = w_fire && baout && w_is_r0;

  always_ff @(posedge clock) begin
    if (clear) r_r0_zero <= 1'b0;
    else       r_r0_zero <= w_r0z;
  end
  assign r0_zero = r_r0_zero;
`else
  assign w_rd_en = w_fire && (rout || baout);
  assign r0_zero = 1'b0;
`endif

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_in (
    .i_idx    (w_idx),
    .i_en     (w_wr_en),
    .o_onehot (w_in_oh)
  );

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_out (
    .i_idx    (w_idx),
    .i_en     (w_rd_en),
    .o_onehot (w_out_oh)
  );

  // Decode above reads r_ir before this edge's load, so an ir_in in the
  // same cycle as a strobe decodes the previous instruction.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_ir        <= '0;
      r_reg_in    <= '0;
      r_reg_out   <= '0;
      r_sel_idx   <= '0;
      r_sel_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      if (ir_in) r_ir <= instr;
      r_reg_in    <= w_in_oh;
      r_reg_out   <= w_out_oh;
      r_sel_valid <= w_fire;
      if (w_fire)  r_sel_idx <= w_idx;
      if (w_multi) r_sel_err <= 1'b1;
    end
  end

  assign reg_in    = r_reg_in;
  assign reg_out   = r_reg_out;
  assign sel_idx   = r_sel_idx;
  assign sel_valid = r_sel_valid;
  assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_select_unit
// Purpose  : Self-checking bench for reg_select_unit. Two instances (16 and
//            32 registers) share control strobes; a behavioural model checks
//            every output each cycle, and directed scenarios add literal
//            expectations. Honours REG_SELECT_R0_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_select_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, ir_in, gra, grb, grc, rin, rout, baout;
  logic [31:0] instr16, instr32;

  logic [31:0] c16, c32;
  logic [15:0] in16, out16;
  logic [31:0] in32, out32;
  logic [3:0]  idx16;
  logic [4:0]  idx32;
  logic        v16, e16, z16, v32, e32, z32;

  reg_select_unit #(.NUM_REGS(16)) dut16 (
    .clock(clk), .clear(clear), .ir_in(ir_in), .instr(instr16),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .c_sign_extended(c16), .reg_in(in16), .reg_out(out16), .sel_idx(idx16),
    .sel_valid(v16), .sel_err(e16), .r0_zero(z16)
  );

  reg_select_unit #(.NUM_REGS(32)) dut32 (
    .clock(clk), .clear(clear), .ir_in(ir_in), .instr(instr32),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .c_sign_extended(c32), .reg_in(in32), .reg_out(out32), .sel_idx(idx32),
    .sel_valid(v32), .sel_err(e32), .r0_zero(z32)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model (index 0: 16 regs, 1: 32 regs) -----
  logic [31:0] m_ir[2], m_in[2], m_out[2];
  int          m_idx[2];
  bit          m_valid[2], m_err[2], m_r0z[2];
  bit          m_live = 0;
  int          t_iw, t_nsel, t_f, t_id;
  bit          t_fire, t_rd, t_r0;

  function automatic logic [31:0] sext(input logic [31:0] ir, input int cw);
    longint one, c;
    one = 1;
    c = longint'(ir) & ((one << cw) - 1);
    if (c >= (one << (cw - 1))) c = c - (one << cw);
    return 32'(c);
  endfunction

  always @(posedge clk) begin
    if (clear) m_live = 1;
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        m_ir[k] = 0; m_in[k] = 0; m_out[k] = 0; m_idx[k] = 0;
        m_valid[k] = 0; m_err[k] = 0; m_r0z[k] = 0;
      end else begin
        t_iw   = (k == 0) ? 4 : 5;
        t_nsel = int'(gra) + int'(grb) + int'(grc);
        t_f    = gra ? 0 : (grb ? 1 : 2);
        t_id   = int'((m_ir[k] >> (27 - (t_f + 1) * t_iw)) & ((32'd1 << t_iw) - 1));
        t_fire = (t_nsel == 1) && (rin || rout || baout);
`ifdef REG_SELECT_R0_ZERO_EN
        t_rd = rout || (baout && t_id != 0);
        t_r0 = t_fire && baout && t_id == 0;
`else
        t_rd = rout || baout;
        t_r0 = 0;
`endif
        m_in[k]    = (t_fire && rin)  ? (32'd1 << t_id) : 32'd0;
        m_out[k]   = (t_fire && t_rd) ? (32'd1 << t_id) : 32'd0;
        m_valid[k] = t_fire;
        m_r0z[k]   = t_r0;
        if (t_fire) m_idx[k] = t_id;
        if (t_nsel >= 2) m_err[k] = 1;
        if (ir_in) m_ir[k] = (k == 0) ? instr16 : instr32;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m16_cse",   c16,          sext(m_ir[0], 15));
      chk("m16_in",    32'(in16),    m_in[0]);
      chk("m16_out",   32'(out16),   m_out[0]);
      chk("m16_idx",   32'(idx16),   32'(m_idx[0]));
      chk("m16_valid", 32'(v16),     32'(m_valid[0]));
      chk("m16_err",   32'(e16),     32'(m_err[0]));
      chk("m16_r0z",   32'(z16),     32'(m_r0z[0]));
      chk("m32_cse",   c32,          sext(m_ir[1], 12));
      chk("m32_in",    in32,         m_in[1]);
      chk("m32_out",   out32,        m_out[1]);
      chk("m32_idx",   32'(idx32),   32'(m_idx[1]));
      chk("m32_valid", 32'(v32),     32'(m_valid[1]));
      chk("m32_err",   32'(e32),     32'(m_err[1]));
      chk("m32_r0z",   32'(z32),     32'(m_r0z[1]));
    end
  end

  // ---------------- directed stimulus -------------------------------------
  function automatic logic [31:0] mk16(input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [3:0] rc, input logic [14:0] c);
    return {5'b10011, ra, rb, rc, c};
  endfunction

  function automatic logic [31:0] mk32(input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [4:0] rc, input logic [11:0] c);
    return {5'b01101, ra, rb, rc, c};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {clear, ir_in, gra, grb, grc, rin, rout, baout} = '0;
  endtask

  initial begin
    idle();
    instr16 = '0; instr32 = '0;
    clear = 1'b1;
    cyc();
    idle();
    chk("rst_out16", 32'(out16), 32'h0);
    chk("rst_err16", 32'(e16), 32'h0);
    chk("rst_cse16", c16, 32'h0);
    chk("rst_valid32", 32'(v32), 32'h0);

    // ra sweep at 16 registers
    for (int r = 0; r < 16; r++) begin
      instr16 = mk16(4'(r), 4'd2, 4'd5, 15'h0123);
      instr32 = mk32(5'(r + 16), 5'd1, 5'd2, 12'h0);
      ir_in = 1'b1; cyc(); ir_in = 1'b0;
      gra = 1'b1; rout = 1'b1; cyc(); idle();
      chk($sformatf("sweep_out16_r%0d", r), 32'(out16), 32'd1 << r);
      chk($sformatf("sweep_in16_r%0d", r), 32'(in16), 32'h0);
    end

    // rc = 31 write at 32 registers
    instr32 = mk32(5'd3, 5'd4, 5'd31, 12'h0);
    ir_in = 1'b1; cyc(); ir_in = 1'b0;
    grc = 1'b1; rin = 1'b1; cyc(); idle();
    chk("rc31_in32", in32, 32'h8000_0000);
    chk("rc31_idx32", 32'(idx32), 32'd31);
    chk("rc31_valid32", 32'(v32), 32'd1);
    cyc();
    chk("rc31_valid32_once", 32'(v32), 32'd0);
    chk("rc31_idx32_hold", 32'(idx32), 32'd31);

    // C-field sign extension
    instr16 = mk16(4'd1, 4'd2, 4'd3, 15'h4000);
    instr32 = mk32(5'd1, 5'd2, 5'd3, 12'h7FF);
    ir_in = 1'b1; cyc(); ir_in = 1'b0;
    chk("cse16_neg", c16, 32'hFFFF_C000);
    chk("cse32_pos", c32, 32'h0000_07FF);

    // conflicting select, sticky error, clear
    gra = 1'b1; grb = 1'b1; rout = 1'b1; cyc(); idle();
    chk("multi_out16", 32'(out16), 32'h0);
    chk("multi_err16", 32'(e16), 32'd1);
    for (int i = 0; i < 5; i++) begin
      gra = 1'b1; rout = 1'b1; cyc(); idle();
    end
    chk("err16_sticky", 32'(e16), 32'd1);
    chk("err16_sticky_out", 32'(out16), 32'd1 << 1);
    clear = 1'b1; cyc(); idle();
    chk("err16_cleared", 32'(e16), 32'd0);
    chk("ir16_cleared", c16, 32'h0);

    // old IR is decoded in the load cycle
    instr16 = mk16(4'd7, 4'd0, 4'd0, 15'h0);
    ir_in = 1'b1; cyc();
    instr16 = mk16(4'd3, 4'd0, 4'd0, 15'h0);
    gra = 1'b1; rout = 1'b1; cyc(); ir_in = 1'b0;
    chk("oldir_out16", 32'(out16), 32'd1 << 7);
    cyc(); idle();
    chk("newir_out16", 32'(out16), 32'd1 << 3);

    // baout of R0
    instr16 = mk16(4'd0, 4'd0, 4'd0, 15'h0);
    instr32 = mk32(5'd0, 5'd0, 5'd0, 12'h0);
    ir_in = 1'b1; cyc(); ir_in = 1'b0;
    gra = 1'b1; baout = 1'b1; cyc(); idle();
`ifdef REG_SELECT_R0_ZERO_EN
    chk("r0_out16", 32'(out16), 32'h0);
    chk("r0_zero16", 32'(z16), 32'd1);
    chk("r0_valid16", 32'(v16), 32'd1);
    chk("r0_idx16", 32'(idx16), 32'd0);
`else
    chk("r0_out16", 32'(out16), 32'd1);
    chk("r0_zero16", 32'(z16), 32'd0);
`endif

    // rin + rout together at rb = 9
    instr16 = mk16(4'd4, 4'd9, 4'd6, 15'h7FFF);
    ir_in = 1'b1; cyc(); ir_in = 1'b0;
    grb = 1'b1; rin = 1'b1; rout = 1'b1; cyc(); idle();
    chk("both_in16", 32'(in16), 32'd1 << 9);
    chk("both_out16", 32'(out16), 32'd1 << 9);

    // select without strobe, strobe without select
    grc = 1'b1; cyc(); idle();
    chk("nostrobe_valid16", 32'(v16), 32'd0);
    rin = 1'b1; cyc(); idle();
    chk("nosel_in16", 32'(in16), 32'h0);
    chk("nosel_idx16", 32'(idx16), 32'd9);

    // clear overrides a coincident strobe and ir_in
    gra = 1'b1; rout = 1'b1; ir_in = 1'b1; clear = 1'b1; cyc(); idle();
    chk("clr_out16", 32'(out16), 32'h0);
    chk("clr_valid16", 32'(v16), 32'd0);
    gra = 1'b1; rout = 1'b1; cyc(); idle();
    chk("postclr_out16", 32'(out16), 32'd1);

    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
